pipeline_front_regs: RTL and testbench

Sequential pipeline front end that consumes the stall/flush controls produced by hazard detection: it holds the PC register, the IF/ID register and the ID/EX register, and applies hold, bubble and flush actions to them each cycle. It sits between fetch, decode and execute in the 5-stage MIPS core. Optionally, it carries saturating stall/flush performance counters.

---
 rtl/pipeline_front_regs.sv | 208 ++++++++++++++++++++
 tb/tb_pipeline_front_regs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_front_regs.sv
// pipeline_front_regs
//   Front-end pipeline registers for the 5-stage MIPS core. This block holds
//   the fetch PC, the IF/ID register and the ID/EX register. Each cycle it
//   applies the hold, bubble and flush actions requested by hazard detection.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   pc_stall            : hold the PC
//   if_id_stall/flush   : hold IF/ID / load a NOP into IF/ID (flush wins)
//   id_ex_stall/flush   : hold ID/EX / load a bubble into ID/EX (flush wins)
//   pc_next             : next PC from fetch/branch logic
//   if_instr            : instruction fetched at pc
//   id_ctrl, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd
//                       : decode-stage values captured into ID/EX
//   pc                  : current fetch PC
//   id_pc4, id_instr, id_valid              : IF/ID register contents
//   ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
//   ex_valid                                : ID/EX register contents
//   stall_cycles, flush_cycles              : saturating performance counters
//
// Configuration
//   PIPE_PERF_CNT_EN : when defined, adds the stall_cycles/flush_cycles
//                      ports and their saturating counters.
module pipeline_front_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_stall,
  input  logic              if_id_stall,
  input  logic              if_id_flush,
  input  logic              id_ex_stall,
  input  logic              id_ex_flush,
  input  logic [31:0]       pc_next,
  input  logic [31:0]       if_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  output logic [31:0]       pc,
  output logic [31:0]       id_pc4,
  output logic [31:0]       id_instr,
  output logic              id_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_pc4,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_valid
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles
`endif
);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       id_pc4_q, id_pc4_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic              id_valid_q, id_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [31:0]       ex_pc4_q, ex_pc4_d;
  logic [31:0]       ex_rs_data_q, ex_rs_data_d;
  logic [31:0]       ex_rt_data_q, ex_rt_data_d;
  logic [31:0]       ex_imm_q, ex_imm_d;
  logic [4:0]        ex_rs_q, ex_rs_d;
  logic [4:0]        ex_rt_q, ex_rt_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic              ex_valid_q, ex_valid_d;

  // PC stage: hold on stall, otherwise follow fetch/branch logic
  always_comb begin
    pc_d = pc_stall ? pc_q : pc_next;
  end

  // IF/ID stage: flush > stall > load. pc + 4 wraps silently at 2^32.
  always_comb begin
    id_pc4_d   = id_pc4_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (if_id_flush) begin
      id_pc4_d   = 32'h0;
      id_instr_d = 32'h0;  // sll $0,$0,0
      id_valid_d = 1'b0;
    end else if (!if_id_stall) begin
      id_pc4_d   = pc_q + 32'd4;
      id_instr_d = if_instr;
      id_valid_d = 1'b1;
    end
  end

  // ID/EX stage: flush > stall > load. An all-zero ctrl bundle is a bubble.
  always_comb begin
    ex_ctrl_d    = ex_ctrl_q;
    ex_pc4_d     = ex_pc4_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    ex_valid_d   = ex_valid_q;
    if (id_ex_flush) begin
      ex_ctrl_d    = '0;
      ex_pc4_d     = 32'h0;
      ex_rs_data_d = 32'h0;
      ex_rt_data_d = 32'h0;
      ex_imm_d     = 32'h0;
      ex_rs_d      = 5'd0;
      ex_rt_d      = 5'd0;
      ex_rd_d      = 5'd0;
      ex_valid_d   = 1'b0;
    end else if (!id_ex_stall) begin
      ex_ctrl_d    = id_ctrl;
      ex_pc4_d     = id_pc4_q;
      ex_rs_data_d = id_rs_data;
      ex_rt_data_d = id_rt_data;
      ex_imm_d     = id_imm;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;
      ex_rd_d      = id_rd;
      ex_valid_d   = id_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      id_pc4_q     <= 32'h0;
      id_instr_q   <= 32'h0;
      id_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_pc4_q     <= 32'h0;
      ex_rs_data_q <= 32'h0;
      ex_rt_data_q <= 32'h0;
      ex_imm_q     <= 32'h0;
      ex_rs_q      <= 5'd0;
      ex_rt_q      <= 5'd0;
      ex_rd_q      <= 5'd0;
      ex_valid_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      id_pc4_q     <= id_pc4_d;
      id_instr_q   <= id_instr_d;
      id_valid_q   <= id_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_pc4_q     <= ex_pc4_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_valid_q   <= ex_valid_d;
    end
  end

  assign pc         = pc_q;
  assign id_pc4     = id_pc4_q;
  assign id_instr   = id_instr_q;
  assign id_valid   = id_valid_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_pc4     = ex_pc4_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign ex_valid   = ex_valid_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Increment unless already pinned at all-ones
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Counter stage: one event per edge at most
  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, pc_stall);
    flush_cnt_d = sat_inc(flush_cnt_q, if_id_flush | id_ex_flush);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_front_regs.sv
module tb_pipeline_front_regs;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic [31:0]   pc_next, if_instr;
  logic [CW-1:0] id_ctrl;
  logic [31:0]   id_rs_data, id_rt_data, id_imm;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [31:0]   pc, id_pc4, id_instr;
  logic          id_valid;
  logic [CW-1:0] ex_ctrl;
  logic [31:0]   ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic          ex_valid;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_cycles;
`endif

  pipeline_front_regs #(.RESET_PC(32'h0000_3000), .CTRL_W(CW)) dut (
    .clk(clk), .reset(reset),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .pc_next(pc_next), .if_instr(if_instr), .id_ctrl(id_ctrl),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .pc(pc), .id_pc4(id_pc4), .id_instr(id_instr), .id_valid(id_valid),
    .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a snapshot of what each register stage should hold.
  typedef struct {
    logic [31:0] instr, pc4;
    logic        valid;
  } ifid_t;
  typedef struct {
    logic [CW-1:0] ctrl;
    logic [31:0]   pc4, rs_data, rt_data, imm;
    logic [4:0]    rs, rt, rd;
    logic          valid;
  } idex_t;

  logic [31:0] m_pc;
  ifid_t       m_id;
  idex_t       m_ex;
  longint      m_stall_n, m_flush_n;  // unbounded event counts, clamped on compare

  task automatic model_step();
    ifid_t id_new;
    idex_t ex_new;
    if (reset) begin
      m_pc = 32'h0000_3000;
      m_id = '{32'h0, 32'h0, 1'b0};
      m_ex = '{'0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0};
      m_stall_n = 0;
      m_flush_n = 0;
      return;
    end
    if (id_ex_flush)      ex_new = '{'0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0};
    else if (id_ex_stall) ex_new = m_ex;
    else ex_new = '{id_ctrl, m_id.pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, m_id.valid};
    if (if_id_flush)      id_new = '{32'h0, 32'h0, 1'b0};
    else if (if_id_stall) id_new = m_id;
    else id_new = '{if_instr, 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000), 1'b1};
    m_ex = ex_new;
    m_id = id_new;
    if (!pc_stall) m_pc = pc_next;
    if (pc_stall) m_stall_n++;
    if (if_id_flush || id_ex_flush) m_flush_n++;
  endtask

  function automatic logic [31:0] clamp32(input longint n);
    return (n > 64'sh0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(n);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},         pc, m_pc);
    check({tag, ".id_instr"},   id_instr, m_id.instr);
    check({tag, ".id_pc4"},     id_pc4, m_id.pc4);
    check({tag, ".id_valid"},   32'(id_valid), 32'(m_id.valid));
    check({tag, ".ex_ctrl"},    32'(ex_ctrl), 32'(m_ex.ctrl));
    check({tag, ".ex_pc4"},     ex_pc4, m_ex.pc4);
    check({tag, ".ex_rs_data"}, ex_rs_data, m_ex.rs_data);
    check({tag, ".ex_rt_data"}, ex_rt_data, m_ex.rt_data);
    check({tag, ".ex_imm"},     ex_imm, m_ex.imm);
    check({tag, ".ex_rs"},      32'(ex_rs), 32'(m_ex.rs));
    check({tag, ".ex_rt"},      32'(ex_rt), 32'(m_ex.rt));
    check({tag, ".ex_rd"},      32'(ex_rd), 32'(m_ex.rd));
    check({tag, ".ex_valid"},   32'(ex_valid), 32'(m_ex.valid));
`ifdef PIPE_PERF_CNT_EN
    check({tag, ".stall_cycles"}, stall_cycles, clamp32(m_stall_n));
    check({tag, ".flush_cycles"}, flush_cycles, clamp32(m_flush_n));
`endif
  endtask

  // One clock: inputs are stable across the edge; outputs sampled 1ns after.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ctl(input logic [4:0] c);
    {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush} = c;
  endtask

  typedef struct {
    logic [4:0]    ctl;      // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush}
    logic [31:0]   pc_next, instr;
    logic [31:0]   e_pc, e_id_instr, e_id_pc4;
    logic          e_id_valid;
    logic [31:0]   e_ex_pc4;
    logic          e_ex_valid;
    logic [CW-1:0] e_ex_ctrl;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{5'b00000, 32'h0000_3004, 32'h2008_0005, 32'h0000_3004, 32'h2008_0005, 32'h0000_3004, 1'b1, 32'h0000_0000, 1'b0, 12'hABC};
    vecs[1] = '{5'b00000, 32'h0000_3008, 32'h1111_1111, 32'h0000_3008, 32'h1111_1111, 32'h0000_3008, 1'b1, 32'h0000_3004, 1'b1, 12'hABC};
    vecs[2] = '{5'b11001, 32'h0000_300C, 32'h2222_2222, 32'h0000_3008, 32'h1111_1111, 32'h0000_3008, 1'b1, 32'h0000_0000, 1'b0, 12'h000};
    vecs[3] = '{5'b00000, 32'h0000_300C, 32'h3333_3333, 32'h0000_300C, 32'h3333_3333, 32'h0000_300C, 1'b1, 32'h0000_3008, 1'b1, 12'hABC};
    vecs[4] = '{5'b00100, 32'h0000_3100, 32'h4444_4444, 32'h0000_3100, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_300C, 1'b1, 12'hABC};
    vecs[5] = '{5'b00000, 32'h0000_3104, 32'h5555_5555, 32'h0000_3104, 32'h5555_5555, 32'h0000_3104, 1'b1, 32'h0000_0000, 1'b0, 12'hABC};
    vecs[6] = '{5'b01100, 32'h0000_3108, 32'h6666_6666, 32'h0000_3108, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_3104, 1'b1, 12'hABC};
    vecs[7] = '{5'b00010, 32'hFFFF_FFFC, 32'h7777_7777, 32'hFFFF_FFFC, 32'h7777_7777, 32'h0000_310C, 1'b1, 32'h0000_3104, 1'b1, 12'hABC};
    vecs[8] = '{5'b00011, 32'h0000_0000, 32'h8888_8888, 32'h0000_0000, 32'h8888_8888, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 12'h000};
    vecs[9] = '{5'b00000, 32'h0000_0004, 32'h9999_9999, 32'h0000_0004, 32'h9999_9999, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b1, 12'hABC};

    reset = 1'b1;
    set_ctl(5'b11111);
    pc_next = 32'hDEAD_BEE0; if_instr = 32'hFFFF_FFFF;
    id_ctrl = 12'hABC; id_rs_data = 32'h1234_5678; id_rt_data = 32'h8765_4321;
    id_imm = 32'hFFFF_FF80; id_rs = 5'd3; id_rt = 5'd7; id_rd = 5'd31;

    // Reset held two cycles with every control asserted
    #1;
    cycle();
    cycle();
    check("rst.pc", pc, 32'h0000_3000);
    check("rst.id_valid", 32'(id_valid), 32'd0);
    check("rst.ex_valid", 32'(ex_valid), 32'd0);
    check("rst.ex_ctrl", 32'(ex_ctrl), 32'd0);
    check_all("rst");

    // Directed table, starting from the reset state
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_ctl(vecs[i].ctl);
      pc_next  = vecs[i].pc_next;
      if_instr = vecs[i].instr;
      cycle();
      check($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
      check($sformatf("vec%0d.id_instr", i), id_instr, vecs[i].e_id_instr);
      check($sformatf("vec%0d.id_pc4", i), id_pc4, vecs[i].e_id_pc4);
      check($sformatf("vec%0d.id_valid", i), 32'(id_valid), 32'(vecs[i].e_id_valid));
      check($sformatf("vec%0d.ex_pc4", i), ex_pc4, vecs[i].e_ex_pc4);
      check($sformatf("vec%0d.ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_ex_valid));
      check($sformatf("vec%0d.ex_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].e_ex_ctrl));
      check_all($sformatf("vec%0d", i));
    end

    // Reset arriving mid-stall clears everything on that edge
    set_ctl(5'b11010);
    pc_next = 32'h0000_5000;
    cycle();
    check_all("stall");
    reset = 1'b1;
    cycle();
    check("midrst.pc", pc, 32'h0000_3000);
    check("midrst.id_instr", id_instr, 32'h0);
    check("midrst.id_valid", 32'(id_valid), 32'd0);
    check("midrst.ex_valid", 32'(ex_valid), 32'd0);
    check("midrst.ex_ctrl", 32'(ex_ctrl), 32'd0);
    check_all("midrst");

    // First edge after reset release loads pc_next
    reset = 1'b0;
    set_ctl(5'b00000);
    pc_next = 32'h0000_3040;
    cycle();
    check("post_rst.pc", pc, 32'h0000_3040);
    check_all("post_rst");

`ifdef PIPE_PERF_CNT_EN
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_ctl(5'b10000);
    repeat (3) cycle();
    set_ctl(5'b00001);
    repeat (2) cycle();
    check("cnt.stall3", stall_cycles, 32'd3);
    check("cnt.flush2", flush_cycles, 32'd2);
    // Preload both counters to all-ones, then keep the events coming
    set_ctl(5'b10100);
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    force dut.flush_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    release dut.flush_cnt_q;
    m_stall_n = 64'h0000_0000_FFFF_FFFF;
    m_flush_n = 64'h0000_0000_FFFF_FFFF;
    repeat (2) cycle();
    check("cnt.stall_sat", stall_cycles, 32'hFFFF_FFFF);
    check("cnt.flush_sat", flush_cycles, 32'hFFFF_FFFF);
    check_all("cnt");
`endif

    // Randomized run against the model
    for (int n = 0; n < 500; n++) begin
      reset       = ($urandom_range(0, 39) == 0);
      pc_stall    = ($urandom_range(0, 3) == 0);
      if_id_stall = ($urandom_range(0, 3) == 0);
      if_id_flush = ($urandom_range(0, 4) == 0);
      id_ex_stall = ($urandom_range(0, 3) == 0);
      id_ex_flush = ($urandom_range(0, 4) == 0);
      pc_next     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      if_instr    = $urandom();
      id_ctrl     = CW'($urandom());
      id_rs_data  = $urandom();
      id_rt_data  = $urandom();
      id_imm      = $urandom();
      id_rs       = 5'($urandom());
      id_rt       = 5'($urandom());
      id_rd       = 5'($urandom());
      cycle();
      check_all($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
